// File: rtl/run_ctrl_if.sv
// Groups the run-control inputs (mode, step, halt, breakpoint) and CPU pacing outputs.
// Pure wiring; no latency of its own.
// No backpressure: every signal is a level sampled each CLOCK_50 cycle.
interface run_ctrl_if #(
    parameter int CE_W = 32
);
    logic [1:0]      mode_sw;
    logic            step_btn;
    logic            halt_req;
    logic [31:0]     pc;
    logic [31:0]     bkpt_addr;
    logic            bkpt_en;
    logic            cpu_ce;
    logic [1:0]      state;
    logic [CE_W-1:0] ce_count;

    // Operator/CPU side drives the controls and observes the pacing outputs.
    modport master (
        output mode_sw, step_btn, halt_req, pc, bkpt_addr, bkpt_en,
        input  cpu_ce, state, ce_count
    );

    // The run controller consumes the controls and produces the pacing outputs.
    modport slave (
        input  mode_sw, step_btn, halt_req, pc, bkpt_addr, bkpt_en,
        output cpu_ce, state, ce_count
    );
endinterface

// File: rtl/run_ctrl.sv
// CPU run controller: paces cpu_ce in normal/slow/step modes and handles halt/breakpoints.
// cpu_ce is registered: it rises one cycle after the tick or step edge that causes it.
// No backpressure; the CPU must consume each one-cycle cpu_ce pulse as it appears.
module run_ctrl #(
    parameter int DIV_NORMAL = 25,
    parameter int DIV_SLOW   = 50000000,
    parameter int CNT_W      = 29,
    parameter int CE_W       = 32
) (
    input  logic     CLOCK_50,
    input  logic     rst_n,
    run_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'b00,
        ST_RUN     = 2'b01,
        ST_STEP    = 2'b10,
        ST_HALTED  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LIM_NORMAL = CNT_W'(DIV_NORMAL - 1);
    localparam logic [CNT_W-1:0] LIM_SLOW   = CNT_W'(DIV_SLOW - 1);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              ce_q;
    logic              ce_d;
    logic              btn_prev_q;
    logic [1:0]        mode_prev_q;
    logic [CE_W-1:0]   ce_count_q;

    logic              step_edge;
    logic              rate_change;
    logic              at_limit;
    logic              tick;
    logic              bkpt_hit;

    assign step_edge   = bus.step_btn & ~btn_prev_q;
    // A swap between normal and slow rate restarts the period from zero.
    assign rate_change = ~bus.mode_sw[1] & ~mode_prev_q[1]
                       & (bus.mode_sw[0] ^ mode_prev_q[0]);
    assign at_limit    = (cnt_q == (bus.mode_sw[0] ? LIM_SLOW : LIM_NORMAL));
    assign tick        = (state_q == ST_RUN) & at_limit & ~rate_change;
    assign bkpt_hit    = bus.bkpt_en & (bus.pc == bus.bkpt_addr);

    // Next state, next tick count and next clock-enable; halt_req outranks mode changes.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        ce_d    = 1'b0;
        case (state_q)
            ST_STOPPED: begin
                case (bus.mode_sw)
                    2'b00, 2'b01: state_d = ST_RUN;
                    2'b10:        state_d = ST_STEP;
                    default:      state_d = ST_STOPPED;
                endcase
            end
            ST_RUN: begin
                if (bus.halt_req) begin
                    state_d = ST_HALTED;
                end else if (bus.mode_sw == 2'b11) begin
                    state_d = ST_STOPPED;
                end else if (bus.mode_sw == 2'b10) begin
                    state_d = ST_STEP;
                end else if (tick) begin
                    if (bkpt_hit) begin
                        state_d = ST_HALTED;
                    end else begin
                        ce_d = 1'b1;
                    end
                end else if (!rate_change) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STEP: begin
                if (bus.halt_req) begin
                    state_d = ST_HALTED;
                end else if (!bus.mode_sw[1]) begin
                    state_d = ST_RUN;
                end else if (bus.mode_sw == 2'b11) begin
                    state_d = ST_STOPPED;
                end else if (step_edge) begin
                    ce_d = 1'b1;
                end
            end
            ST_HALTED: begin
                if (bus.mode_sw == 2'b11) begin
                    state_d = ST_STOPPED;
                end
            end
            default: state_d = ST_STOPPED;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_q <= ST_STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    // Tick counter, pulse register, edge/mode history and pulse counter.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            ce_q        <= 1'b0;
            btn_prev_q  <= 1'b1;
            mode_prev_q <= 2'b00;
            ce_count_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            ce_q        <= ce_d;
            btn_prev_q  <= bus.step_btn;
            mode_prev_q <= bus.mode_sw;
            ce_count_q  <= ce_count_q + CE_W'(ce_q);
        end
    end

    assign bus.cpu_ce   = ce_q;
    assign bus.state    = state_q;
    assign bus.ce_count = ce_count_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: directed scenarios plus random stimulus against a reference model.
// A second small-counter instance exercises ce_count wrap-around.
// Expected responses are queued at stimulus time and checked by an independent monitor.
module tb_run_ctrl;

    localparam int NORM = 4;
    localparam int SLOW = 7;
    localparam int S_STOP = 0;
    localparam int S_RUN  = 1;
    localparam int S_STEP = 2;
    localparam int S_HALT = 3;

    logic CLOCK_50;
    logic rst_n;
    logic rst2_n;

    run_ctrl_if #(.CE_W(32)) bus ();
    run_ctrl_if #(.CE_W(8))  bus2 ();

    run_ctrl #(.DIV_NORMAL(NORM), .DIV_SLOW(SLOW), .CNT_W(29), .CE_W(32)) dut (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    run_ctrl #(.DIV_NORMAL(1), .DIV_SLOW(1), .CNT_W(29), .CE_W(8)) dut_wrap (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst2_n),
        .bus      (bus2)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic        ce;
        logic [1:0]  st;
        logic [31:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_no   = 0;

    // Reference model: the controller's observable behaviour in plain terms.
    int          m_state = S_STOP;
    int          m_phase = 0;       // cycles elapsed in the current tick period
    bit          m_btn_was = 1'b1;
    logic [1:0]  m_mode_was = 2'b00;
    bit          m_pulse = 1'b0;
    logic [31:0] m_pulses = 32'd0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc_no, got, want);
        end
    endtask

    // Predict the outputs after the coming rising edge from the inputs now applied.
    task automatic model_step();
        int   nxt;
        bit   pulse;
        bit   pressed;
        bit   swapped;
        int   period;
        exp_t e;
        if (!rst_n) begin
            m_state = S_STOP; m_phase = 0; m_btn_was = 1'b1;
            m_mode_was = 2'b00; m_pulse = 1'b0; m_pulses = 32'd0;
        end else begin
            nxt     = m_state;
            pulse   = 1'b0;
            pressed = bus.step_btn && !m_btn_was;
            swapped = (bus.mode_sw inside {2'b00, 2'b01}) && (m_mode_was inside {2'b00, 2'b01})
                      && (bus.mode_sw != m_mode_was);
            period  = (bus.mode_sw == 2'b01) ? SLOW : NORM;
            if (m_state == S_STOP) begin
                if (bus.mode_sw == 2'b10) nxt = S_STEP;
                else if (bus.mode_sw != 2'b11) nxt = S_RUN;
                m_phase = 0;
            end else if (m_state == S_HALT) begin
                if (bus.mode_sw == 2'b11) nxt = S_STOP;
                m_phase = 0;
            end else if (bus.halt_req) begin
                nxt = S_HALT; m_phase = 0;
            end else if (bus.mode_sw == 2'b11) begin
                nxt = S_STOP; m_phase = 0;
            end else if (m_state == S_STEP) begin
                if (bus.mode_sw == 2'b10) pulse = pressed;
                else nxt = S_RUN;
                m_phase = 0;
            end else if (bus.mode_sw == 2'b10) begin
                nxt = S_STEP; m_phase = 0;
            end else if (swapped) begin
                m_phase = 0;
            end else if (m_phase + 1 == period) begin
                m_phase = 0;
                if (bus.bkpt_en && bus.pc == bus.bkpt_addr) nxt = S_HALT;
                else pulse = 1'b1;
            end else begin
                m_phase = m_phase + 1;
            end
            if (m_pulse) m_pulses = m_pulses + 32'd1;
            m_pulse    = pulse;
            m_state    = nxt;
            m_btn_was  = bus.step_btn;
            m_mode_was = bus.mode_sw;
        end
        e.ce    = m_pulse;
        e.st    = 2'(m_state);
        e.count = m_pulses;
        exp_q.push_back(e);
    endtask

    // Apply one cycle of inputs at the falling edge and queue the expected response.
    task automatic cyc(input logic r, input logic [1:0] m, input logic b, input logic h,
                       input logic [31:0] p, input logic be);
        @(negedge CLOCK_50);
        rst_n        = r;
        bus.mode_sw  = m;
        bus.step_btn = b;
        bus.halt_req = h;
        bus.pc       = p;
        bus.bkpt_en  = be;
        model_step();
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLOCK_50);
            #1;
            cyc_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cpu_ce",   32'(bus.cpu_ce), 32'(e.ce));
                check("state",    32'(bus.state),  32'(e.st));
                check("ce_count", bus.ce_count,    e.count);
            end
        end
    end

    initial begin
        logic [1:0]  rmode;
        logic        rbtn;
        logic [31:0] pcs [4];
        int          seen;
        bit          wrapped;
        logic [7:0]  prev_cnt;

        pcs[0] = 32'h1c; pcs[1] = 32'h20; pcs[2] = 32'h24; pcs[3] = 32'h100;
        rst_n = 1'b0; rst2_n = 1'b0;
        bus.mode_sw = 2'b10; bus.step_btn = 1'b1; bus.halt_req = 1'b0;
        bus.pc = 32'h0; bus.bkpt_addr = 32'h20; bus.bkpt_en = 1'b0;
        bus2.mode_sw = 2'b00; bus2.step_btn = 1'b0; bus2.halt_req = 1'b0;
        bus2.pc = 32'h0; bus2.bkpt_addr = 32'h0; bus2.bkpt_en = 1'b0;

        // Button held through reset, then stepping: held-high/low/high gives two pulses.
        repeat (3)   cyc(0, 2'b10, 1, 0, 0, 0);
        repeat (5)   cyc(1, 2'b10, 1, 0, 0, 0);
        repeat (3)   cyc(1, 2'b10, 0, 0, 0, 0);
        repeat (100) cyc(1, 2'b10, 1, 0, 0, 0);
        repeat (3)   cyc(1, 2'b10, 0, 0, 0, 0);
        repeat (5)   cyc(1, 2'b10, 1, 0, 0, 0);
        @(posedge CLOCK_50); #2;
        check("step_pulse_total", bus.ce_count, 32'd2);

        // Fresh reset into normal run: pulses every NORM cycles, three pulses counted.
        repeat (2) cyc(0, 2'b00, 0, 0, 0, 0);
        repeat (14) cyc(1, 2'b00, 0, 0, 0, 0);
        @(posedge CLOCK_50); #2;
        check("run_three_pulses", bus.ce_count, 32'd3);
        check("run_state", 32'(bus.state), 32'd1);

        // Normal -> slow mid-count restarts the period.
        repeat (1)  cyc(1, 2'b00, 0, 0, 0, 0);
        repeat (20) cyc(1, 2'b01, 0, 0, 0, 0);
        repeat (3)  cyc(1, 2'b00, 0, 0, 0, 0);
        repeat (9)  cyc(1, 2'b01, 0, 0, 0, 0);

        // Breakpoint at 0x20 halts; halted ignores step edges, ticks and halt_req.
        repeat (12) cyc(1, 2'b00, 0, 0, 32'h20, 1);
        for (int i = 0; i < 10; i++) cyc(1, 2'b00, 1'(i % 2), 1'(i == 3), 32'h20, 1);
        @(posedge CLOCK_50); #2;
        check("bkpt_halted", 32'(bus.state), 32'd3);
        repeat (2) cyc(1, 2'b11, 0, 0, 32'h20, 1);
        repeat (2) cyc(1, 2'b10, 0, 0, 32'h20, 1);
        repeat (3) cyc(1, 2'b10, 1, 0, 32'h20, 1);
        repeat (2) cyc(1, 2'b10, 0, 0, 32'h20, 1);

        // halt_req together with slow -> stop: halt wins.
        repeat (6) cyc(1, 2'b01, 0, 0, 0, 0);
        cyc(1, 2'b11, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) cyc(1, 2'b01, 1'(i % 2), 0, 0, 0);
        @(posedge CLOCK_50); #2;
        check("halt_priority", 32'(bus.state), 32'd3);
        repeat (2) cyc(1, 2'b11, 0, 0, 0, 0);

        // Reset mid-run.
        repeat (7) cyc(1, 2'b00, 0, 0, 0, 0);
        cyc(0, 2'b00, 0, 0, 0, 0);
        @(posedge CLOCK_50); #2;
        check("reset_ce", 32'(bus.cpu_ce), 32'd0);
        check("reset_count", bus.ce_count, 32'd0);
        repeat (6) cyc(1, 2'b00, 0, 0, 0, 0);

        // Randomised operation.
        rmode = 2'b00; rbtn = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) rmode = 2'($urandom_range(3));
            if ($urandom_range(2) == 0)  rbtn  = ~rbtn;
            cyc(1'($urandom_range(299) != 0), rmode, rbtn, 1'($urandom_range(49) == 0),
                pcs[$urandom_range(3)], 1'($urandom_range(1)));
        end

        repeat (3) @(posedge CLOCK_50);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Narrow counter instance: one pulse per cycle, must wrap 0xFF -> 0x00.
        @(negedge CLOCK_50);
        rst2_n = 1'b1;
        seen = 0; wrapped = 1'b0; prev_cnt = 8'd0;
        for (int i = 0; i < 300; i++) begin
            @(posedge CLOCK_50); #3;
            check("wrap_count", 32'(bus2.ce_count), 32'(seen % 256));
            if (prev_cnt == 8'hff && bus2.ce_count == 8'h00) wrapped = 1'b1;
            prev_cnt = bus2.ce_count;
            if (bus2.cpu_ce) seen++;
        end
        check("wrap_seen", 32'(wrapped), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter: DIV_NORMAL, default 25, CLOCK_50 cycles per tick in normal run mode (legal range 1 to 2^CNT_W-1).
REQ-002 Parameter: DIV_SLOW, default 50000000, CLOCK_50 cycles per tick in slow run mode (legal range 1 to 2^CNT_W-1).
REQ-003 Parameter: CNT_W, default 29, width of the tick counter.
REQ-004 CLOCK_50  in  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 mode_sw  in  2  run mode: 00 normal, 01 slow, 10 step, 11 stop; already synchronous to CLOCK_50.
REQ-007 step_btn  in  1  debounced step button level, synchronous to CLOCK_50.
REQ-008 halt_req  in  1  CPU halt request level (halt instruction decoded).
REQ-009 pc  in  32  current CPU program counter.
REQ-010 bkpt_addr  in  32  breakpoint address.
REQ-011 bkpt_en  in  1  breakpoint enable.
REQ-012 cpu_ce  out  1  registered one-cycle CPU clock-enable pulse; one pulse equals one CPU cycle.
REQ-013 state  out  2  FSM state: 00 STOPPED, 01 RUN, 10 STEP, 11 HALTED.
REQ-014 ce_count  out  32  count of cpu_ce pulses issued.

Function
REQ-015 The tick counter SHALL count 0 to div-1, where div is DIV_NORMAL for mode_sw=00 and DIV_SLOW for mode_sw=01; a tick occurs in the cycle where cnt==div-1, and cnt then returns to 0.
REQ-016 The tick counter SHALL count only in RUN and SHALL be held at 0 in all other states.
REQ-017 cnt SHALL be cleared to 0 in the cycle after mode_sw changes between 00 and 01, with no tick issued in that cycle.
REQ-018 In RUN, cpu_ce SHALL be 1 in the cycle after a tick, unless that tick is suppressed by REQ-019 or REQ-020.
REQ-019 Breakpoint hit = bkpt_en and pc==bkpt_addr at a tick in RUN: no cpu_ce is issued for that tick and the next state is HALTED.
REQ-020 halt_req=1 in RUN or STEP: next state HALTED and no cpu_ce is issued that cycle; halt_req has priority over every other transition, including mode_sw=11.
REQ-021 Step edge = step_btn & ~btn_prev, where btn_prev is registered each cycle.
REQ-022 In STEP, each step edge SHALL produce exactly one cpu_ce pulse on the following cycle; breakpoints are ignored in STEP, so stepping past bkpt_addr is allowed.
REQ-023 STOPPED transitions:
  - mode_sw 00 or 01 -> RUN
  - mode_sw 10 -> STEP
  - mode_sw 11 -> remain in STOPPED
REQ-024 RUN transitions:
  - mode_sw 11 -> STOPPED
  - mode_sw 10 -> STEP
  - the tick in flight is discarded on exit
REQ-025 STEP transitions:
  - mode_sw 00 or 01 -> RUN, with cnt starting at 0
  - mode_sw 11 -> STOPPED
REQ-026 HALTED SHALL ignore halt_req, breakpoints, step edges and ticks, and SHALL exit only to STOPPED when mode_sw==11; the operator must pass through stop to resume.
REQ-027 cpu_ce SHALL be 0 in STOPPED and HALTED and SHALL never be high for two consecutive cycles when DIV_NORMAL>=2.
REQ-028 ce_count SHALL increment by 1 on each cycle where cpu_ce=1 and SHALL wrap from FFFFFFFF to 0.
REQ-029 state SHALL reflect the registered FSM state, with no combinational path from inputs to outputs.

Reset
REQ-030 When rst_n=0 at a rising edge, the block SHALL set:
  - state=STOPPED
  - cpu_ce=0
  - cnt=0
  - ce_count=0
  - btn_prev=1, so a button held through reset produces no step
REQ-031 Reset applied mid-RUN or mid-STEP SHALL abort any pending pulse, and cpu_ce SHALL be 0 in the first cycle after reset.
REQ-032 After reset release, the FSM SHALL evaluate mode_sw on the first active edge per REQ-023.

Verification
REQ-033 Reset release with mode_sw=00 and DIV_NORMAL=4 -> state=RUN after 1 cycle; cpu_ce pulses every 4 cycles; ce_count=3 after 3 pulses.
REQ-034 STEP mode with step_btn held high 100 cycles, then low, then high -> exactly 2 cpu_ce pulses, each 1 cycle wide; btn held through reset -> 0 pulses.
REQ-035 RUN with bkpt_en=1 and pc reaching bkpt_addr=0x20 -> no cpu_ce at that tick; state=11; mode_sw=11 -> state=00; mode_sw=10 then step edge -> one pulse with pc still 0x20.
REQ-036 halt_req=1 in the same cycle as mode_sw 01->11 -> state=HALTED and no cpu_ce; HALTED holds under step edges and ticks.
REQ-037 Switch mode_sw 00->01 mid-count with cnt=2 -> cnt=0; next pulse after DIV_SLOW cycles; rst_n=0 mid-run -> cpu_ce=0, ce_count=0.
REQ-038 Preload ce_count=FFFFFFFF via pulses in a reduced-width test -> wraps to 0 on the next pulse.
